// File: rtl/id_stage_if.sv
// IF/ID-to-ID/EX bundle for the decode stage.
// Carries fetched pc/instruction, flags, write-back port and decoded controls.
interface id_stage_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] pc_in;
    logic [31:0]       instruction;
    logic [3:0]        status;
    logic              hazard;
    logic              wb_en;
    logic [3:0]        wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic [DATA_W-1:0] pc_out;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en_out;
    logic              s_out;
    logic              b_out;
    logic              imm;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              two_src;

    modport slave (
        input  pc_in, instruction, status, hazard,
        input  wb_en, wb_dest, wb_value,
        output pc_out, exe_cmd, mem_r_en, mem_w_en,
        output wb_en_out, s_out, b_out, imm,
        output val_rn, val_rm, shift_operand,
        output signed_imm_24, dest, src1, src2, two_src
    );

    modport master (
        output pc_in, instruction, status, hazard,
        output wb_en, wb_dest, wb_value,
        input  pc_out, exe_cmd, mem_r_en, mem_w_en,
        input  wb_en_out, s_out, b_out, imm,
        input  val_rn, val_rm, shift_operand,
        input  signed_imm_24, dest, src1, src2, two_src
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: register file, ARM-style decoder,
// condition check against NZCV, bubble insertion on hazard.
module id_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 16
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  io
);
    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic       is_str;
    logic [3:0] rm_idx;

    logic [3:0] cmd;
    logic       mr;
    logic       mw;
    logic       wb;
    logic       s;
    logic       br;
    logic       cond_ok;
    logic       n_f, z_f, c_f, v_f;
    logic       bubble;

    assign mode   = io.instruction[27:26];
    assign opcode = io.instruction[24:21];
    assign s_bit  = io.instruction[20];
    assign rn     = io.instruction[19:16];
    assign rd     = io.instruction[15:12];
    assign rm     = io.instruction[3:0];
    assign is_str = (mode == 2'b01) && !s_bit;
    assign rm_idx = is_str ? rd : rm;

    assign {n_f, z_f, c_f, v_f} = io.status;

    // Register file: reset to R[i]=i, reset wins over write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= DATA_W'(i);
        end else if (io.wb_en) begin
            regs[io.wb_dest] <= io.wb_value;
        end
    end

    // Operand read with same-cycle write-back bypass.
    always_comb begin
        io.val_rn = regs[rn];
        io.val_rm = regs[rm_idx];
        if (io.wb_en && io.wb_dest == rn)
            io.val_rn = io.wb_value;
        if (io.wb_en && io.wb_dest == rm_idx)
            io.val_rm = io.wb_value;
    end

    // Raw control decode from mode/opcode/S.
    always_comb begin
        cmd = 4'b0000;
        mr  = 1'b0;
        mw  = 1'b0;
        wb  = 1'b0;
        s   = 1'b0;
        br  = 1'b0;
        case (mode)
            2'b00: begin
                wb = 1'b1;
                s  = s_bit;
                case (opcode)
                    4'b1101: cmd = 4'b0001;
                    4'b1111: cmd = 4'b1001;
                    4'b0100: cmd = 4'b0010;
                    4'b0101: cmd = 4'b0011;
                    4'b0010: cmd = 4'b0100;
                    4'b0110: cmd = 4'b0101;
                    4'b0000: cmd = 4'b0110;
                    4'b1100: cmd = 4'b0111;
                    4'b0001: cmd = 4'b1000;
                    4'b1010: begin
                        cmd = 4'b0100;
                        wb  = 1'b0;
                    end
                    4'b1000: begin
                        cmd = 4'b0110;
                        wb  = 1'b0;
                    end
                    default: begin
                        wb = 1'b0;
                        s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                cmd = 4'b0010;
                s   = s_bit;
                mr  = s_bit;
                wb  = s_bit;
                mw  = !s_bit;
            end
            2'b10: br = 1'b1;
            default: ;
        endcase
    end

    // Condition field evaluated against NZCV.
    always_comb begin
        cond_ok = 1'b0;
        case (io.instruction[31:28])
            4'h0: cond_ok = z_f;
            4'h1: cond_ok = !z_f;
            4'h2: cond_ok = c_f;
            4'h3: cond_ok = !c_f;
            4'h4: cond_ok = n_f;
            4'h5: cond_ok = !n_f;
            4'h6: cond_ok = v_f;
            4'h7: cond_ok = !v_f;
            4'h8: cond_ok = c_f && !z_f;
            4'h9: cond_ok = !c_f || z_f;
            4'hA: cond_ok = (n_f == v_f);
            4'hB: cond_ok = (n_f != v_f);
            4'hC: cond_ok = !z_f && (n_f == v_f);
            4'hD: cond_ok = z_f || (n_f != v_f);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign bubble = io.hazard || !cond_ok;

    assign io.exe_cmd   = bubble ? 4'b0000 : cmd;
    assign io.mem_r_en  = mr && !bubble;
    assign io.mem_w_en  = mw && !bubble;
    assign io.wb_en_out = wb && !bubble;
    assign io.s_out     = s && !bubble;
    assign io.b_out     = br && !bubble;

    assign io.pc_out        = io.pc_in;
    assign io.imm           = io.instruction[25];
    assign io.shift_operand = io.instruction[11:0];
    assign io.signed_imm_24 = io.instruction[23:0];
    assign io.dest          = rd;
    assign io.src1          = rn;
    assign io.src2          = rm_idx;
    assign io.two_src       = !io.instruction[25] || is_str;
endmodule
